mem_arbiter: RTL and testbench

- Two-master arbiter sharing the picorv32-style native memory bus (valid/ready, addr, wdata, wstrb, instr, rdata) between master 0 (CPU) and master 1 (DMA/debug loader).
- Sits between the masters and the existing address decode/slave mux, and presents one master-side bus to the slaves.
- Round-robin grant, locked for the whole transaction.
- Bus timeout watchdog that force-completes hung transactions and records the error.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the picorv32-style native memory bus.
// Master 0 (CPU) and master 1 (DMA/debug loader) share one slave-side bus.
// Grants are round-robin and stay locked for a whole transaction.
// A watchdog force-completes hung transactions. It answers the master with
// ERR_DATA and records the address of the first transaction that hung.
module mem_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    input  logic        err_clr,
    output logic        err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // The watchdog fires on the cycle in which the timer reaches this value.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic        last_reg, last_next;
    logic [15:0] timer_reg;
    logic        err_reg;
    logic [31:0] err_addr_reg;

    logic        timeout_hit;
    logic        done;

    // Forward the granted master to the slave side. The bus stays all-zero while idle.
    always_comb begin
        s_valid = 1'b0;
        s_instr = 1'b0;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_wstrb = 4'd0;
        case (state_reg)
            GNT0: begin
                s_valid = m0_valid;
                s_instr = m0_instr;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
            GNT1: begin
                s_valid = m1_valid;
                s_instr = m1_instr;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end
            default: ;
        endcase
    end

    // Completion decode. A real s_ready beats the watchdog in the same cycle.
    always_comb begin
        timeout_hit = (state_reg != IDLE) && s_valid && !s_ready
                      && (timer_reg == TIMEOUT_LAST);
        done        = s_valid && (s_ready || timeout_hit);
        m0_ready    = (state_reg == GNT0) && done;
        m1_ready    = (state_reg == GNT1) && done;
        m0_rdata    = 32'd0;
        m1_rdata    = 32'd0;
        if (state_reg == GNT0)
            m0_rdata = timeout_hit ? ERR_DATA : s_rdata;
        if (state_reg == GNT1)
            m1_rdata = timeout_hit ? ERR_DATA : s_rdata;
    end

    // Next-state logic: round-robin grant out of IDLE.
    // The grant is released on completion, or when the master abandons its request.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    if (last_reg) begin
                        state_next = GNT0;
                        last_next  = 1'b0;
                    end else begin
                        state_next = GNT1;
                        last_next  = 1'b1;
                    end
                end else if (m0_valid) begin
                    state_next = GNT0;
                    last_next  = 1'b0;
                end else if (m1_valid) begin
                    state_next = GNT1;
                    last_next  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (!s_valid || done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and round-robin history registers. last starts at 1 so master 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    // Watchdog timer. It is held at zero while idle, so every grant starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer_reg <= 16'd0;
        else if (state_reg == IDLE)
            timer_reg <= 16'd0;
        else if (!s_ready)
            timer_reg <= timer_reg + 16'd1;
    end

    // Sticky error flag and first-error address. A new timeout has priority over err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg      <= 1'b0;
            err_addr_reg <= 32'd0;
        end else if (timeout_hit) begin
            err_reg <= 1'b1;
            if (!err_reg)
                err_addr_reg <= s_addr;
        end else if (err_clr) begin
            err_reg      <= 1'b0;
            err_addr_reg <= 32'd0;
        end
    end

    assign err      = err_reg;
    assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.
// Inputs are driven on the falling clock edge, and outputs are checked 1 ns later.
// The DUT is built with TIMEOUT=8.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err_clr, err;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (m0_valid),
        .m0_instr (m0_instr),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_instr (m1_instr),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_instr  (s_instr),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .err_clr  (err_clr),
        .err      (err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to the next falling edge, the point where stimulus is changed.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Master 0 reads addr, and the slave never answers.
    // The watchdog must complete the read on the 8th s_valid cycle.
    task automatic m0_timeout_read(input logic [31:0] addr, input logic [31:0] exp_err_addr);
        next_cycle();
        m0_valid = 1'b1; m0_addr = addr; m0_wstrb = 4'd0; s_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            #1;
            check($sformatf("to_ready_c%0d", k), {31'd0, m0_ready}, (k == 8) ? 32'd1 : 32'd0);
            if (k == 8)
                check("to_rdata", m0_rdata, 32'hDEADBEEF);
        end
        next_cycle();
        m0_valid = 1'b0;
        #1;
        check("to_idle_after", {31'd0, s_valid}, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_err_addr", err_addr, exp_err_addr);
        $display("txn timeout m0 addr=0x%08h err=%0d err_addr=0x%08h", addr, err, err_addr);
    endtask

    // Expected contention pattern: 0 = idle, 1 = m0 granted, 2 = m1 granted.
    int unsigned cont_pat [8] = '{1, 0, 2, 0, 1, 0, 2, 0};

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0; err_clr = 0;

        // Reset state
        next_cycle();
        #1;
        check("rst_s_valid", {31'd0, s_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        next_cycle();
        reset = 1'b0;

        // Single master read. The slave answers on the 2nd s_valid cycle.
        next_cycle();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        #1;
        check("single_lat0_s_valid", {31'd0, s_valid}, 32'd0);
        next_cycle();
        #1;
        check("single_s_valid", {31'd0, s_valid}, 32'd1);
        check("single_s_addr", s_addr, 32'h0000_0100);
        check("single_ready_early", {31'd0, m0_ready}, 32'd0);
        next_cycle();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        check("single_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("single_m0_rdata", m0_rdata, 32'h1234_5678);
        check("single_m1_ready", {31'd0, m1_ready}, 32'd0);
        check("single_m1_rdata", m1_rdata, 32'd0);
        next_cycle();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("single_ready_once", {31'd0, m0_ready}, 32'd0);
        check("single_idle", {31'd0, s_valid}, 32'd0);
        $display("txn single m0 read addr=0x00000100 rdata=0x12345678");

        // Write forwarding from m1
        next_cycle();
        m1_valid = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
        next_cycle();
        #1;
        check("wr_s_wstrb", {28'd0, s_wstrb}, 32'h3);
        check("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
        check("wr_s_addr", s_addr, 32'h8000_0000);
        s_ready = 1'b1;
        #1;
        check("wr_m1_ready", {31'd0, m1_ready}, 32'd1);
        check("wr_m0_ready", {31'd0, m0_ready}, 32'd0);
        next_cycle();
        m1_valid = 1'b0; m1_wstrb = 4'd0; s_ready = 1'b0;
        $display("txn write m1 addr=0x80000000 wdata=0xA5A5A5A5 wstrb=0011");

        // Contention from reset, with the slave always ready
        reset = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0000_1000;
        m1_valid = 1'b1; m1_addr = 32'h0000_2000;
        s_ready = 1'b1; s_rdata = 32'h0;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            #1;
            check($sformatf("cont%0d_s_valid", i), {31'd0, s_valid}, (cont_pat[i] != 0) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_m0_ready", i), {31'd0, m0_ready}, (cont_pat[i] == 1) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_m1_ready", i), {31'd0, m1_ready}, (cont_pat[i] == 2) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_s_addr", i), s_addr,
                  (cont_pat[i] == 1) ? 32'h0000_1000 : (cont_pat[i] == 2) ? 32'h0000_2000 : 32'd0);
            $display("txn contention cycle %0d grant=%0d s_addr=0x%08h", i, cont_pat[i], s_addr);
            if (i == 7) begin
                m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
            end
        end

        // Timeouts: the first one records the address, the second leaves it alone
        m0_timeout_read(32'h9000_0000, 32'h9000_0000);
        m0_timeout_read(32'h9000_0004, 32'h9000_0000);
        next_cycle();
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        #1;
        check("clr_err", {31'd0, err}, 32'd0);
        check("clr_err_addr", err_addr, 32'd0);
        $display("txn err_clr err=%0d err_addr=0x%08h", err, err_addr);

        // s_ready arrives in the timeout cycle, so this is a normal completion
        next_cycle();
        m0_valid = 1'b1; m0_addr = 32'h9000_0008;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            if (k == 8) begin
                s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
            end
            #1;
            if (k == 8) begin
                check("race_m0_ready", {31'd0, m0_ready}, 32'd1);
                check("race_m0_rdata", m0_rdata, 32'hCAFE_F00D);
            end
        end
        next_cycle();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("race_err", {31'd0, err}, 32'd0);
        $display("txn ready-at-timeout m0 rdata=0xCAFEF00D err=%0d", err);

        // m1 drops valid while it holds the grant
        next_cycle();
        m1_valid = 1'b1; m1_addr = 32'h0000_3000;
        next_cycle();
        #1;
        check("drop_s_valid", {31'd0, s_valid}, 32'd1);
        m1_valid = 1'b0;
        #1;
        check("drop_m1_ready", {31'd0, m1_ready}, 32'd0);
        next_cycle();
        m1_valid = 1'b1; s_ready = 1'b1;
        #1;
        check("drop_back_idle", {31'd0, s_valid}, 32'd0);
        check("drop_no_ready", {31'd0, m1_ready}, 32'd0);
        next_cycle();
        #1;
        check("drop_regrant_ready", {31'd0, m1_ready}, 32'd1);
        check("drop_err", {31'd0, err}, 32'd0);
        next_cycle();
        m1_valid = 1'b0; s_ready = 1'b0;
        $display("txn m1 drop-valid then regrant");

        // Reset asserted during GNT0
        next_cycle();
        m0_valid = 1'b1; m0_addr = 32'h0000_4000;
        next_cycle();
        #1;
        check("rstmid_granted", {31'd0, s_valid}, 32'd1);
        m1_valid = 1'b1; m1_addr = 32'h0000_5000;
        #1;
        reset = 1'b1;
        s_ready = 1'b1;
        #1;
        check("rstmid_s_valid", {31'd0, s_valid}, 32'd0);
        check("rstmid_m0_ready", {31'd0, m0_ready}, 32'd0);
        check("rstmid_m1_ready", {31'd0, m1_ready}, 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        #1;
        check("rstmid_m0_first", {31'd0, m0_ready}, 32'd1);
        check("rstmid_s_addr", s_addr, 32'h0000_4000);
        check("rstmid_m1_wait", {31'd0, m1_ready}, 32'd0);
        next_cycle();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        $display("txn reset-mid-grant m0 first after release");

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
